// File: rtl/iter_countdown.sv
// iter_countdown: loadable down-counter and iteration sequencer with a start/busy/done handshake.
// Define ITER_COUNTDOWN_AUTO_RELOAD_EN to reload the latched count at each completion.
module iter_countdown #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             step
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
`ifdef ITER_COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] load_q, load_d;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef ITER_COUNTDOWN_AUTO_RELOAD_EN
    load_d  = load_q;
`endif
    case (state_q)
      IDLE: if (start && !abort) begin
        if (load_val != '0) begin
          state_d = RUN;
          count_d = load_val;
`ifdef ITER_COUNTDOWN_AUTO_RELOAD_EN
          load_d  = load_val;
`endif
        end else done_d = 1'b1;
      end
      RUN: if (abort) begin
        state_d = IDLE;
        count_d = '0;
      end else if (en) begin
        if (count_q == WIDTH'(1)) begin
          done_d  = 1'b1;
`ifdef ITER_COUNTDOWN_AUTO_RELOAD_EN
          count_d = load_q;
`else
          state_d = IDLE;
          count_d = '0;
`endif
        end else count_d = count_q - WIDTH'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef ITER_COUNTDOWN_AUTO_RELOAD_EN
      load_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef ITER_COUNTDOWN_AUTO_RELOAD_EN
      load_q  <= load_d;
`endif
    end
  end
  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign step  = busy & en & ~abort;
endmodule

// File: doc/iter_countdown.md
Name: iter_countdown

Overview:
- Loadable down-counter and iteration sequencer for multicycle execute units (serial multiply/divide, shifters).
- Counterpart to the up-counting iteration counter: it is loaded with an iteration count and drains it toward zero.
- Provides a start/busy/done handshake to the issuing control logic.
- Provides a per-cycle step strobe to the datapath.

Parameters:
- WIDTH, 6, counter width in bits; max load value 2^WIDTH-1 (63 at default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; highest priority.
- start  input  1  request to begin a sequence; sampled only in IDLE.
- load_val  input  WIDTH  iteration count, captured when start is accepted.
- en  input  1  tick enable; one iteration consumed per cycle with en=1 while busy.
- abort  input  1  cancel the running sequence; no done is produced.
- count  output  WIDTH  remaining iterations (registered).
- busy  output  1  high while a sequence is running (registered).
- done  output  1  one-cycle completion pulse (registered).
- step  output  1  combinational busy & en & ~abort; datapath advance strobe.

Behaviour:
- Reset (rst=1 at an edge): count=0, busy=0, done=0, state=IDLE, latched load value=0. rst overrides start, en and abort.
- States: IDLE, RUN. done is a registered flag, not a separate state.
- done defaults to 0 every cycle unless set by a rule below, so it is never high for two consecutive cycles from the same sequence.
- IDLE, start=1, abort=0, load_val!=0: count<=load_val, busy<=1, go to RUN.
- IDLE, start=1, abort=0, load_val==0: zero-length sequence. done<=1 next cycle; busy stays 0; count stays 0; remain IDLE.
- IDLE, abort=1: start is ignored and nothing changes.
- RUN, abort=1: count<=0, busy<=0, done stays 0, go to IDLE. abort takes priority over en.
- RUN, en=0: hold count; busy stays 1.
- RUN, en=1, count>1: count<=count-1.
- RUN, en=1, count==1: count<=0, busy<=0, done<=1, go to IDLE.
- start while in RUN is ignored; there is no restart and no queueing.
- Timing with en held high and load_val=N>0 accepted at edge E0:
  - busy=1 for exactly N cycles (after E0 through E_N-1);
  - step is high in each of those N cycles;
  - count=0, busy=0, done=1 in the cycle after edge E_N.
- A new start is accepted in the same cycle that done=1, since the block is back in IDLE. This gives back-to-back sequences with no bubble beyond the done cycle.
- Arithmetic is unsigned modulo 2^WIDTH, but count never underflows: no decrement occurs at count==0.
- Reset mid-sequence aborts silently; no done is produced.

Optional Feature:
- Macro: ITER_COUNTDOWN_AUTO_RELOAD_EN.
- Defined: load_val is latched on start. In RUN, en=1 with count==1 does the following:
  - count<=latched value;
  - busy stays 1;
  - done<=1 for that one cycle;
  - state remains RUN.
  - This produces periodic done pulses every N enabled cycles. Only abort or rst ends the sequence.
  - A zero load value behaves as in one-shot mode: single done pulse, no RUN.
- Undefined: one-shot behaviour as above; the latch register is not synthesized.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles with start=1 -> count=0, busy=0, done=0 throughout and after release.
2. Basic run: start with load_val=5, en=1 constant -> busy high 5 cycles, count 5,4,3,2,1, then count=0, busy=0, done=1 for exactly 1 cycle; step high 5 cycles.
3. Stall: load_val=3, en pattern 1,0,0,1,1 -> count 3,2,2,2,1, then done=1; step low in the en=0 cycles.
4. Abort and simultaneous events:
   - load_val=10, abort at count=6 with en=1 the same cycle -> next cycle count=0, busy=0, done never asserted.
   - start and abort together in IDLE -> no state change.
5. Edge values:
   - load_val=0 -> done=1 one cycle after start, busy never high.
   - load_val=63 -> busy for 63 cycles.
   - start during RUN is ignored.
   - new start in the done cycle is accepted.
6. With ITER_COUNTDOWN_AUTO_RELOAD_EN: load_val=4, en=1 for 12 cycles -> done pulses after the 4th, 8th and 12th enabled cycles; busy stays 1; abort then clears to IDLE with no done.
